// File: rtl/mips_pkg.sv
// Shared types for the MIPS instruction-fetch front end.
package mips_pkg;

  typedef logic [31:0] instr_t;
  typedef logic [31:0] pc_t;

  // All-zero word is sll $0,$0,0 -- the canonical MIPS no-op.
  localparam instr_t MIPS_NOP = 32'h0000_0000;

  // One prefetched instruction together with the PC+4 that ID needs for
  // branch-target and link computation.
  typedef struct packed {
    instr_t instr;
    pc_t    pc4;
  } fetch_entry_t;

  // Sequential successor of a byte PC; wraps modulo 2^32.
  function automatic pc_t pc_next(input pc_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy count.
// Storage is not reset; only pointers and count are. Push into a full FIFO
// is accepted when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointer advance that also works for non-power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (ptr == PW'(DEPTH - 1)) return '0;
    return ptr + PW'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one edge.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Data storage write; flushed pushes are dropped.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues pipelined word reads to
// instruction memory (req/gnt/rvalid), buffers returns in a prefetch queue
// and hands them to ID over valid/ready. A redirect flushes the queue and
// marks every in-flight request for discard.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int          QDEPTH    = 4,
  parameter int          MAX_OUTST = 2,
  parameter int          AW        = 30,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_gnt_i,
  input  logic          imem_rvalid_i,
  input  logic [31:0]   imem_rdata_i,
  input  logic          redirect_i,
  input  logic [31:0]   redirect_pc_i,
  input  logic          id_ready_i,
  output logic          if_valid_o,
  output logic [31:0]   if_instr_o,
  output logic [31:0]   if_pc4_o,
  output logic [31:0]   pc_o
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int TW = $clog2(MAX_OUTST) + 1;
  localparam int EW = $bits(fetch_entry_t);
  localparam logic [CW:0]   QDEPTH_L    = (CW+1)'(QDEPTH);
  localparam logic [CW-1:0] MAX_OUTST_L = CW'(MAX_OUTST);

  pc_t           pc;
  logic          running;
  logic [CW-1:0] outst;
  logic [CW-1:0] discard;

  logic          credit_ok;
  logic [CW:0]   in_use;
  logic          issue;
  logic          rv_keep;
  logic          rv_drop;
  logic          pop;

  logic [CW-1:0] q_count;
  logic          q_full;
  logic          q_empty;
  fetch_entry_t  q_push_entry;
  logic [EW-1:0] q_head_bits;
  fetch_entry_t  q_head;

  pc_t           tag_head;
  logic          tag_full;
  logic          tag_empty;
  logic [TW-1:0] tag_count;

  logic          unused_bits;

  // ---- Issue stage: credit check, request, PC advance ----
  // Queue slots already promised to in-flight requests count against the
  // queue, so a return always has room and the queue can never overflow.
  assign in_use      = {1'b0, q_count} + {1'b0, outst};
  assign credit_ok   = (outst < MAX_OUTST_L) && (in_use < QDEPTH_L);
  assign imem_req_o  = running && !redirect_i && credit_ok && !tag_full;
  assign imem_addr_o = pc[AW+1:2];
  assign issue       = imem_req_o && imem_gnt_i;
  assign pc_o        = pc;

  // Hold off the first request until the cycle after reset is released.
  always_ff @(posedge clk) begin
    if (!rst_n) running <= 1'b0;
    else        running <= 1'b1;
  end

  // Fetch PC: redirect target wins, otherwise step on every accepted request.
  always_ff @(posedge clk) begin
    if (!rst_n)          pc <= RESET_PC;
    else if (redirect_i) pc <= redirect_pc_i;
    else if (issue)      pc <= pc_next(pc);
  end

  // Outstanding-request counter: +1 per issue, -1 per return.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outst <= '0;
    end else begin
      case ({issue, imem_rvalid_i})
        2'b10:   outst <= outst + CW'(1);
        2'b01:   outst <= outst - CW'(1);
        default: outst <= outst;
      endcase
    end
  end

  // ---- Return stage: discard stale returns, tag and enqueue fresh ones ----
  // Returns come back in issue order, so stale ones always sit ahead of
  // fresh ones: a single counter is enough to know how many to drop.
  assign rv_drop = imem_rvalid_i && (discard != '0);
  assign rv_keep = imem_rvalid_i && (discard == '0) && !redirect_i && !tag_empty;

  // Discard counter: on redirect every request still unreturned after this
  // cycle becomes stale (outst already includes previously stale ones).
  always_ff @(posedge clk) begin
    if (!rst_n)          discard <= '0;
    else if (redirect_i) discard <= outst - CW'(imem_rvalid_i);
    else if (rv_drop)    discard <= discard - CW'(1);
  end

  // Per-request PC tags, consumed in order as fresh data returns.
  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_i),
    .push      (issue),
    .push_data (pc),
    .pop       (rv_keep),
    .pop_data  (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  assign q_push_entry = '{instr: imem_rdata_i, pc4: pc_next(tag_head)};

  // ---- Delivery stage: prefetch queue head presented to ID ----
  assign pop = if_valid_o && id_ready_i && !redirect_i;

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (QDEPTH)
  ) u_prefetch_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_i),
    .push      (rv_keep),
    .push_data (q_push_entry),
    .pop       (pop),
    .pop_data  (q_head_bits),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Outputs are masked while empty so ID never sees unreset storage.
  assign q_head     = fetch_entry_t'(q_head_bits);
  assign if_valid_o = !q_empty;
  assign if_instr_o = q_empty ? MIPS_NOP : q_head.instr;
  assign if_pc4_o   = q_empty ? '0 : q_head.pc4;

  // Status bits not needed by the control logic above.
  assign unused_bits = ^{q_full, tag_count};

endmodule
